// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// The master modport is the controller. The slave modport is the datapath/memory side.
interface multicycle_controller_if #(
  parameter int COUNT_WIDTH = 32
);
  // datapath / memory status into the controller
  logic [6:0]             opcode;
  logic                   zero;
  logic                   mem_ready;

  // controller outputs
  logic                   mem_request;
  logic                   mem_write;
  logic                   adr_select;
  logic                   ir_write;
  logic                   pc_write;
  logic                   reg_write;
  logic [1:0]             alu_select_a;
  logic [1:0]             alu_select_b;
  logic [1:0]             alu_op;
  logic [2:0]             immediate_select;
  logic [1:0]             result_select;
  logic                   fault;
  logic                   instruction_done;
  logic [COUNT_WIDTH-1:0] instruction_count;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_request, mem_write, adr_select, ir_write, pc_write, reg_write,
           alu_select_a, alu_select_b, alu_op, immediate_select, result_select,
           fault, instruction_done, instruction_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_request, mem_write, adr_select, ir_write, pc_write, reg_write,
           alu_select_a, alu_select_b, alu_op, immediate_select, result_select,
           fault, instruction_done, instruction_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing for a
// shared-ALU, single-memory datapath. It supports lw, sw, R-type, I-type ALU, beq and jal.
// The memory request handshake has a wait timeout. A sticky FAULT state is reached on
// a timeout or an unknown opcode. A retired-instruction counter is provided.
// Optional feature: define UPPER_IMM_EN to add lui/auipc. Without it, both opcodes fault.
// Control outputs come from a per-state control word. That word is registered from the next
// state. Only the documented Mealy terms combine it with live inputs: ir_write/pc_write
// with mem_ready in FETCH, and pc_write with zero in BEQ. The DECODE immediate select uses
// the freshly loaded opcode. Enables are gated by reset, so they are 0 while reset is held.
module multicycle_controller #(
  parameter int MAX_WAIT    = 15,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef UPPER_IMM_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [1:0] RES_IMM  = 2'b11;
`endif

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;

  localparam logic [1:0] SEL_A_PC    = 2'b00;
  localparam logic [1:0] SEL_A_OLDPC = 2'b01;
  localparam logic [1:0] SEL_A_RD1   = 2'b10;
  localparam logic [1:0] SEL_B_RD2   = 2'b00;
  localparam logic [1:0] SEL_B_IMM   = 2'b01;
  localparam logic [1:0] SEL_B_FOUR  = 2'b10;
  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_FUNCT   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Wait counter sized to hold MAX_WAIT-1; a MAX_WAIT of 0 disables the timeout.
  localparam int                WAIT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};
  localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE_R = 4'd6,
    S_EXECUTE_I = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_FAULT     = 4'd11
`ifdef UPPER_IMM_EN
    ,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13
`endif
  } state_t;

  // Per-state control word; fetch/branch are combined with live inputs at the outputs.
  typedef struct packed {
    logic       mem_request;
    logic       mem_write;
    logic       adr_select;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_select_a;
    logic [1:0] alu_select_b;
    logic [1:0] alu_op;
    logic [2:0] immediate_select;
    logic [1:0] result_select;
  } ctrl_t;

  // Immediate format used while decoding: J for jal, B otherwise (branch target precompute).
  function automatic logic [2:0] decode_imm(input logic [6:0] op);
    logic [2:0] imm;
    if (op == OP_JAL) begin
      imm = IMM_J;
    end else begin
      imm = IMM_B;
    end
    return imm;
  endfunction

  // Control word for a given state; anything not set stays 0.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_request   = 1'b1;
        c.fetch         = 1'b1;
        c.alu_select_a  = SEL_A_PC;
        c.alu_select_b  = SEL_B_FOUR;
        c.alu_op        = ALU_ADD;
        c.result_select = RES_ALU;
      end
      S_DECODE: begin
        c.alu_select_a     = SEL_A_OLDPC;
        c.alu_select_b     = SEL_B_IMM;
        c.alu_op           = ALU_ADD;
        c.immediate_select = decode_imm(op);
      end
      S_MEM_ADDR: begin
        c.alu_select_a     = SEL_A_RD1;
        c.alu_select_b     = SEL_B_IMM;
        c.alu_op           = ALU_ADD;
        c.immediate_select = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        c.mem_request = 1'b1;
        c.adr_select  = 1'b1;
      end
      S_MEM_WB: begin
        c.result_select = RES_MEM;
        c.reg_write     = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_request = 1'b1;
        c.mem_write   = 1'b1;
        c.adr_select  = 1'b1;
      end
      S_EXECUTE_R: begin
        c.alu_select_a = SEL_A_RD1;
        c.alu_select_b = SEL_B_RD2;
        c.alu_op       = ALU_FUNCT;
      end
      S_EXECUTE_I: begin
        c.alu_select_a     = SEL_A_RD1;
        c.alu_select_b     = SEL_B_IMM;
        c.alu_op           = ALU_FUNCT;
        c.immediate_select = IMM_I;
      end
      S_ALU_WB: begin
        c.result_select = RES_ALUOUT;
        c.reg_write     = 1'b1;
      end
      S_BEQ: begin
        c.alu_select_a  = SEL_A_RD1;
        c.alu_select_b  = SEL_B_RD2;
        c.alu_op        = ALU_SUB;
        c.result_select = RES_ALUOUT;
        c.branch        = 1'b1;
      end
      S_JAL: begin
        c.alu_select_a  = SEL_A_OLDPC;
        c.alu_select_b  = SEL_B_FOUR;
        c.alu_op        = ALU_ADD;
        c.result_select = RES_ALUOUT;
        c.pc_update     = 1'b1;
      end
`ifdef UPPER_IMM_EN
      S_LUI: begin
        c.immediate_select = IMM_U;
        c.result_select    = RES_IMM;
        c.reg_write        = 1'b1;
      end
      S_AUIPC: begin
        c.alu_select_a     = SEL_A_OLDPC;
        c.alu_select_b     = SEL_B_IMM;
        c.alu_op           = ALU_ADD;
        c.immediate_select = IMM_U;
      end
`endif
      S_FAULT: c = '0;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t                 state_q;
  state_t                 state_d;
  ctrl_t                  ctrl_q;
  logic [WAIT_W-1:0]      wait_q;
  logic                   fault_q;
  logic                   done_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   req_state_s;
  logic                   wait_full_s;
  logic                   retire_from_s;
  logic                   retire_s;
  logic                   wait_clear_s;
  logic                   wait_inc_s;

  assign req_state_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                       (state_q == S_MEM_WRITE);
  // The current request cycle is the last one allowed before a timeout.
  assign wait_full_s = TIMEOUT_EN && (wait_q == WAIT_LAST);

  // Next-state decode; ready wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_full_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R:              state_d = S_EXECUTE_R;
          OP_I:              state_d = S_EXECUTE_I;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef UPPER_IMM_EN
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`endif
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_STORE) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wait_full_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (wait_full_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_EXECUTE_R: state_d = S_ALU_WB;
      S_EXECUTE_I: state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BEQ:       state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
`ifdef UPPER_IMM_EN
      S_LUI:       state_d = S_FETCH;
      S_AUIPC:     state_d = S_ALU_WB;
`endif
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  // States whose exit back to FETCH completes an instruction.
  always_comb begin
    case (state_q)
      S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BEQ: retire_from_s = 1'b1;
`ifdef UPPER_IMM_EN
      S_LUI:                                  retire_from_s = 1'b1;
`endif
      default:                                retire_from_s = 1'b0;
    endcase
  end

  assign retire_s     = retire_from_s && (state_d == S_FETCH);
  assign wait_clear_s = (state_d != state_q) &&
                        ((state_d == S_FETCH) || (state_d == S_MEM_READ) ||
                         (state_d == S_MEM_WRITE));
  assign wait_inc_s   = req_state_s && !bus.mem_ready && (wait_q != WAIT_SAT);

  // State, control word, wait counter, fault flag and retire bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH, 7'b0000000);
      wait_q  <= '0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, bus.opcode);
      fault_q <= (state_d == S_FAULT);
      done_q  <= retire_s;
      if (retire_s) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end else begin
        count_q <= count_q;
      end
      if (wait_clear_s) begin
        wait_q <= '0;
      end else if (wait_inc_s) begin
        wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= wait_q;
      end
    end
  end

  // Enables are forced low during reset; the Mealy terms use the live ready and zero inputs.
  assign bus.mem_request      = reset & ctrl_q.mem_request;
  assign bus.mem_write        = reset & ctrl_q.mem_write;
  assign bus.ir_write         = reset & ctrl_q.fetch & bus.mem_ready;
  assign bus.pc_write         = reset & (ctrl_q.pc_update |
                                         (ctrl_q.branch & bus.zero) |
                                         (ctrl_q.fetch & bus.mem_ready));
  assign bus.reg_write        = reset & ctrl_q.reg_write;
  assign bus.adr_select       = ctrl_q.adr_select;
  assign bus.alu_select_a     = ctrl_q.alu_select_a;
  assign bus.alu_select_b     = ctrl_q.alu_select_b;
  assign bus.alu_op           = ctrl_q.alu_op;
  // The IR only holds the new opcode once DECODE is reached, so decode its immediate live.
  assign bus.immediate_select = (state_q == S_DECODE) ? decode_imm(bus.opcode)
                                                      : ctrl_q.immediate_select;
  assign bus.result_select    = ctrl_q.result_select;
  assign bus.fault            = fault_q;
  assign bus.instruction_done = done_q;
  assign bus.instruction_count = count_q;

endmodule
